line_fifo_router: RTL and testbench
===================================

Name: line_fifo_router

Overview:
- Write-side scheduler for the parallel solver's two line FIFOs: the row-option FIFO and the column-option FIFO.
- During RECEIVE it splits the parser's word stream into the two FIFOs, using per-line option counts to find the row/column boundary.
- During SOLVE it forwards the solver's write-backs to the matching FIFO.
- It tracks each FIFO's occupancy, flags overflow and stream-sequence errors, and raises load_done when the last column line is in.

Parameters:
- MAX_ROWS, 11, maximum board rows.
- MAX_COLS, 11, maximum board columns.
- MAX_NUM_OPTIONS, 84, maximum options per line.
- LINE_W, 16, FIFO word width.
- FIFO_DEPTH, 1024, depth of each line FIFO; occupancy range is 0..FIFO_DEPTH.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  top-level state: 0 RECEIVE, 1 SOLVE, 2 TRANSMIT.
- fifo_clear  in  1  synchronous clear; same pulse as the FIFO srst.
- num_rows  in  clog2(MAX_ROWS)  board rows m; sampled at first header.
- num_cols  in  clog2(MAX_COLS)  board columns n; sampled at first header.
- options_per_line  in  (MAX_ROWS+MAX_COLS)*clog2(MAX_NUM_OPTIONS)  packed option counts; rows first, then columns.
- parse_write  in  1  parser word valid.
- parse_line  in  LINE_W  parser word.
- board_parsed  in  1  parser end-of-board pulse.
- solve_write_r / solve_write_c  in  1 each  solver push requests.
- solve_line_r / solve_line_c  in  LINE_W each  solver push data.
- solve_next_r / solve_next_c  in  1 each  solver pops; also drive FIFO rd_en.
- fifo_full_r / fifo_full_c  in  1 each  FIFO full flags.
- fifo_write_r / fifo_write_c  out  1 each  FIFO wr_en.
- fifo_in_r / fifo_in_c  out  LINE_W each  FIFO din.
- finished_rows  out  1  all row lines written.
- load_done  out  1  all m+n lines written.
- occ_r / occ_c  out  clog2(FIFO_DEPTH+1) each  occupancy.
- err_overflow  out  1  sticky; a write was dropped.
- err_sequence  out  1  sticky; stream malformed.

Behaviour:
- Reset values: every output is 0; the FSM is in HDR.
- Line stream format: one header word per line, then K option words.
  - The header word's low 5 bits hold the line index L.
  - K = options_per_line[L].
  - Lines arrive in order L = 0..m+n-1. Row lines are L < m; column lines are m <= L < m+n.
- FSM, stepped only while mode==RECEIVE:
  - HDR: on parse_write, forward the header to the target FIFO.
    - If L != expected_idx, set err_sequence.
    - Load opt_cnt = K.
    - If K==0, advance expected_idx and stay in HDR; otherwise go to OPTS.
  - OPTS: on parse_write, forward the word and decrement opt_cnt. When it reaches 0, advance expected_idx and return to HDR.
  - On advancing: if expected_idx becomes m, set finished_rows. If it becomes m+n, set load_done and go to LOADED.
  - LOADED: any parse_write sets err_sequence and the word is dropped. The state holds until fifo_clear.
  - board_parsed arriving in any state other than LOADED (or on the same cycle as the last write) sets err_sequence.
- Target selection is made from expected_idx, never from finished_rows, so the boundary word lands in the correct FIFO.
- Outputs are registered with 1-cycle latency. fifo_write_x / fifo_in_x reflect the source of the previous cycle:
  - parser source in RECEIVE;
  - solve_write_x / solve_line_x in SOLVE;
  - no writes in TRANSMIT.
- Solver writes outside SOLVE are ignored (no error). Parser writes outside RECEIVE set err_sequence.
- Full handling: if fifo_full_x or occ_x==FIFO_DEPTH at request time, suppress the write and set err_overflow.
- Occupancy:
  - occ_x increments on an issued fifo_write_x and decrements on solve_next_x when occ_x>0.
  - A simultaneous write and read leaves occ_x unchanged.
  - A pop at occ_x==0 is ignored and sets err_sequence.
- fifo_clear clears the FSM, counters, occupancies, finished_rows, load_done and pending writes. The sticky errors are kept (cleared only by rst_n).
- rst_n asserted mid-load aborts immediately and asynchronously; no partial write is issued after release.

Decomposition:
- Shared package nonogram_pkg:
  - MAX_ROWS, MAX_COLS, MAX_NUM_OPTIONS, LINE_W;
  - mode encodings RECEIVE/SOLVE/TRANSMIT;
  - the route_state_t enum {HDR, OPTS, LOADED};
  - the header index field width.
- One sub-module, fifo_occ_tracker, is instantiated twice (r and c). It handles occupancy up/down counting, the full check, the empty-pop error and the clear.

Test Plan:
- m=2, n=2, counts {2,1,0,3}, stream H0,a,b,H1,c,H2,H3,d,e,f → fifo_r gets H0,a,b,H1,c; fifo_c gets H2,H3,d,e,f; finished_rows asserts 1 cycle after c; load_done 1 cycle after f; occ_r=5, occ_c=5.
- Zero-option boundary: row 1 has K=0 → H1 goes to fifo_r and the next word goes to fifo_c; no err_sequence.
- SOLVE with solve_write_r=1, solve_next_r=1 for 4 cycles at occ_r=5 → occ_r stays 5; fifo_write_r mirrors the request 1 cycle later.
- fifo_full_c=1 during a column option write → no fifo_write_c, err_overflow=1, occ_c unchanged.
- Header index 3 arriving when expected_idx=2, and an extra word in LOADED → err_sequence=1 and the extra word is dropped.
- rst_n low mid-OPTS → all outputs 0 asynchronously; after release the full first-scenario stream reproduces the same results; fifo_clear at occ_r=7 → occ_r=0 next cycle.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared constants and types for the nonogram solver line-FIFO path.
package nonogram_pkg;

  localparam int MAX_ROWS        = 11;
  localparam int MAX_COLS        = 11;
  localparam int MAX_NUM_OPTIONS = 84;
  localparam int LINE_W          = 16;
  localparam int FIFO_DEPTH      = 1024;

  localparam int ROW_W     = $clog2(MAX_ROWS);
  localparam int COL_W     = $clog2(MAX_COLS);
  localparam int OPT_W     = $clog2(MAX_NUM_OPTIONS);
  localparam int NUM_LINES = MAX_ROWS + MAX_COLS;
  localparam int IDX_W     = 5;
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] MODE_RECEIVE  = 2'd0;
  localparam logic [1:0] MODE_SOLVE    = 2'd1;
  localparam logic [1:0] MODE_TRANSMIT = 2'd2;

  typedef enum logic [1:0] {HDR, OPTS, LOADED} route_state_t;

  // Option count for line idx; indices past the table read as zero options.
  function automatic logic [OPT_W-1:0] line_opts(
    input logic [NUM_LINES*OPT_W-1:0] packed_cnt,
    input logic [IDX_W-1:0]           idx
  );
    line_opts = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (idx == IDX_W'(i)) line_opts = packed_cnt[i*OPT_W +: OPT_W];
  endfunction

endpackage

// File: rtl/fifo_occ_tracker.sv
// Occupancy counter for one line FIFO: gates writes on full, flags overflow and empty pops.
// Write issue is combinational; occupancy updates on the same edge the write is registered.
module fifo_occ_tracker
  import nonogram_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr_req,
  input  logic         full,
  input  logic         pop,
  output logic         wr_issue,
  output logic         ovf,
  output logic         pop_err,
  output logic [W-1:0] occ
);

  logic [W-1:0] occ_q, occ_d;
  logic         at_cap, pop_ok;

  always_comb begin
    at_cap   = full || (occ_q == W'(DEPTH));
    wr_issue = wr_req && !at_cap && !clear;
    ovf      = wr_req && at_cap && !clear;
    pop_ok   = pop && (occ_q != '0);
    pop_err  = pop && (occ_q == '0) && !clear;
    occ_d    = occ_q;
    if (clear)                    occ_d = '0;
    else if (wr_issue && !pop_ok) occ_d = occ_q + W'(1);
    else if (pop_ok && !wr_issue) occ_d = occ_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occ = occ_q;

endmodule

// File: rtl/line_fifo_router.sv
// Routes parser words (RECEIVE) or solver write-backs (SOLVE) into the row/column line FIFOs.
// All outputs registered, 1-cycle latency; writes hitting a full FIFO are dropped and flagged.
module line_fifo_router
  import nonogram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       fifo_clear,
  input  logic [ROW_W-1:0]           num_rows,
  input  logic [COL_W-1:0]           num_cols,
  input  logic [NUM_LINES*OPT_W-1:0] options_per_line,
  input  logic                       parse_write,
  input  logic [LINE_W-1:0]          parse_line,
  input  logic                       board_parsed,
  input  logic                       solve_write_r,
  input  logic                       solve_write_c,
  input  logic [LINE_W-1:0]          solve_line_r,
  input  logic [LINE_W-1:0]          solve_line_c,
  input  logic                       solve_next_r,
  input  logic                       solve_next_c,
  input  logic                       fifo_full_r,
  input  logic                       fifo_full_c,
  output logic                       fifo_write_r,
  output logic                       fifo_write_c,
  output logic [LINE_W-1:0]          fifo_in_r,
  output logic [LINE_W-1:0]          fifo_in_c,
  output logic                       finished_rows,
  output logic                       load_done,
  output logic [OCC_W-1:0]           occ_r,
  output logic [OCC_W-1:0]           occ_c,
  output logic                       err_overflow,
  output logic                       err_sequence
);

  route_state_t      state_q;
  logic [IDX_W-1:0]  exp_idx_q;
  logic [OPT_W-1:0]  opt_cnt_q;
  logic [ROW_W-1:0]  m_q;
  logic [COL_W-1:0]  n_q;
  logic              finished_q, load_done_q, wr_r_q, wr_c_q, err_ovf_q, err_seq_q;
  logic [LINE_W-1:0] din_r_q, din_c_q;

  logic              receiving, first_hdr, hdr_fire, opt_fire, accept, to_row, line_end;
  logic              bad_parse, bad_board, req_r, req_c;
  logic [IDX_W-1:0]  hdr_idx, idx_next, m_eff, mn_eff;
  logic [OPT_W-1:0]  hdr_k;
  logic [LINE_W-1:0] din_r, din_c;
  logic              iss_r, iss_c, ovf_r, ovf_c, perr_r, perr_c;

  always_comb begin
    receiving = (mode == MODE_RECEIVE) && !fifo_clear;
    hdr_idx   = parse_line[IDX_W-1:0];
    hdr_k     = line_opts(options_per_line, hdr_idx);
    // Board size is taken live on the very first header, from the latch afterwards.
    first_hdr = (state_q == HDR) && (exp_idx_q == '0);
    m_eff     = first_hdr ? IDX_W'(num_rows) : IDX_W'(m_q);
    mn_eff    = first_hdr ? IDX_W'(num_rows) + IDX_W'(num_cols)
                          : IDX_W'(m_q) + IDX_W'(n_q);
    hdr_fire  = receiving && parse_write && (state_q == HDR);
    opt_fire  = receiving && parse_write && (state_q == OPTS);
    accept    = hdr_fire || opt_fire;
    to_row    = (exp_idx_q < m_eff);
    line_end  = (hdr_fire && (hdr_k == '0)) || (opt_fire && (opt_cnt_q == OPT_W'(1)));
    idx_next  = exp_idx_q + IDX_W'(1);
    bad_parse = (parse_write && !fifo_clear && ((mode != MODE_RECEIVE) || (state_q == LOADED)))
             || (hdr_fire && (hdr_idx != exp_idx_q));
    bad_board = board_parsed && !fifo_clear && (state_q != LOADED);

    req_r = 1'b0;
    req_c = 1'b0;
    din_r = solve_line_r;
    din_c = solve_line_c;
    if (mode == MODE_RECEIVE) begin
      req_r = accept && to_row;
      req_c = accept && !to_row;
      din_r = parse_line;
      din_c = parse_line;
    end else if (mode == MODE_SOLVE) begin
      req_r = solve_write_r;
      req_c = solve_write_c;
    end
  end

  fifo_occ_tracker #(.DEPTH(FIFO_DEPTH), .W(OCC_W)) u_occ_r (
    .clk(clk), .rst_n(rst_n), .clear(fifo_clear), .wr_req(req_r), .full(fifo_full_r),
    .pop(solve_next_r), .wr_issue(iss_r), .ovf(ovf_r), .pop_err(perr_r), .occ(occ_r)
  );

  fifo_occ_tracker #(.DEPTH(FIFO_DEPTH), .W(OCC_W)) u_occ_c (
    .clk(clk), .rst_n(rst_n), .clear(fifo_clear), .wr_req(req_c), .full(fifo_full_c),
    .pop(solve_next_c), .wr_issue(iss_c), .ovf(ovf_c), .pop_err(perr_c), .occ(occ_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      exp_idx_q   <= '0;
      opt_cnt_q   <= '0;
      m_q         <= '0;
      n_q         <= '0;
      finished_q  <= 1'b0;
      load_done_q <= 1'b0;
      wr_r_q      <= 1'b0;
      wr_c_q      <= 1'b0;
      din_r_q     <= '0;
      din_c_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      wr_r_q <= iss_r;
      wr_c_q <= iss_c;
      if (iss_r) din_r_q <= din_r;
      if (iss_c) din_c_q <= din_c;
      if (ovf_r || ovf_c) err_ovf_q <= 1'b1;
      if (bad_parse || bad_board || perr_r || perr_c) err_seq_q <= 1'b1;

      if (fifo_clear) begin
        state_q     <= HDR;
        exp_idx_q   <= '0;
        opt_cnt_q   <= '0;
        m_q         <= '0;
        n_q         <= '0;
        finished_q  <= 1'b0;
        load_done_q <= 1'b0;
      end else begin
        if (hdr_fire && first_hdr) begin
          m_q <= num_rows;
          n_q <= num_cols;
        end
        if (hdr_fire)      opt_cnt_q <= hdr_k;
        else if (opt_fire) opt_cnt_q <= opt_cnt_q - OPT_W'(1);
        if (line_end) begin
          exp_idx_q <= idx_next;
          if (idx_next == m_eff) finished_q <= 1'b1;
          if (idx_next == mn_eff) begin
            load_done_q <= 1'b1;
            state_q     <= LOADED;
          end else begin
            state_q <= HDR;
          end
        end else if (hdr_fire) begin
          state_q <= OPTS;
        end
      end
    end
  end

  assign fifo_write_r  = wr_r_q;
  assign fifo_write_c  = wr_c_q;
  assign fifo_in_r     = din_r_q;
  assign fifo_in_c     = din_c_q;
  assign finished_rows = finished_q;
  assign load_done     = load_done_q;
  assign err_overflow  = err_ovf_q;
  assign err_sequence  = err_seq_q;

endmodule

// File: tb/tb_line_fifo_router.sv
// Randomized bench for line_fifo_router against a line-list reference model.
module tb_line_fifo_router;
  import nonogram_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [1:0]                 mode = MODE_RECEIVE;
  logic                       fifo_clear = 1'b0;
  logic [ROW_W-1:0]           num_rows = '0;
  logic [COL_W-1:0]           num_cols = '0;
  logic [NUM_LINES*OPT_W-1:0] options_per_line = '0;
  logic                       parse_write = 1'b0;
  logic [LINE_W-1:0]          parse_line = '0;
  logic                       board_parsed = 1'b0;
  logic                       solve_write_r = 1'b0, solve_write_c = 1'b0;
  logic [LINE_W-1:0]          solve_line_r = '0, solve_line_c = '0;
  logic                       solve_next_r = 1'b0, solve_next_c = 1'b0;
  logic                       fifo_full_r = 1'b0, fifo_full_c = 1'b0;
  logic                       fifo_write_r, fifo_write_c;
  logic [LINE_W-1:0]          fifo_in_r, fifo_in_c;
  logic                       finished_rows, load_done;
  logic [OCC_W-1:0]           occ_r, occ_c;
  logic                       err_overflow, err_sequence;

  line_fifo_router dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fifo_clear(fifo_clear),
    .num_rows(num_rows), .num_cols(num_cols), .options_per_line(options_per_line),
    .parse_write(parse_write), .parse_line(parse_line), .board_parsed(board_parsed),
    .solve_write_r(solve_write_r), .solve_write_c(solve_write_c),
    .solve_line_r(solve_line_r), .solve_line_c(solve_line_c),
    .solve_next_r(solve_next_r), .solve_next_c(solve_next_c),
    .fifo_full_r(fifo_full_r), .fifo_full_c(fifo_full_c),
    .fifo_write_r(fifo_write_r), .fifo_write_c(fifo_write_c),
    .fifo_in_r(fifo_in_r), .fifo_in_c(fifo_in_c),
    .finished_rows(finished_rows), .load_done(load_done),
    .occ_r(occ_r), .occ_c(occ_c),
    .err_overflow(err_overflow), .err_sequence(err_sequence)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cnt[NUM_LINES];
  logic [LINE_W-1:0] exp_r[$], exp_c[$], got_r[$], got_c[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Every issued FIFO write, in order, as the FIFOs would see it.
  always @(negedge clk) begin
    if (fifo_write_r) got_r.push_back(fifo_in_r);
    if (fifo_write_c) got_c.push_back(fifo_in_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LINE_W-1:0] w);
    parse_write = 1'b1;
    parse_line  = w;
    tick();
    parse_write = 1'b0;
  endtask

  task automatic set_counts(input int m, input int n);
    logic [NUM_LINES*OPT_W-1:0] opl;
    opl = '0;
    for (int l = 0; l < NUM_LINES; l++) opl[l*OPT_W +: OPT_W] = OPT_W'(cnt[l]);
    options_per_line = opl;
    num_rows = ROW_W'(m);
    num_cols = COL_W'(n);
  endtask

  task automatic do_clear();
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    check("clr_occ_r", 32'(occ_r), 0);
    check("clr_occ_c", 32'(occ_c), 0);
    check("clr_load_done", 32'(load_done), 0);
    check("clr_finished", 32'(finished_rows), 0);
  endtask

  // Streams a whole board; lines below m belong to the row FIFO, the rest to the column FIFO.
  task automatic run_board(input int m, input int n, input bit gaps);
    int done;
    set_counts(m, n);
    exp_r.delete(); exp_c.delete(); got_r.delete(); got_c.delete();
    done = 0;
    for (int l = 0; l < m + n; l++) begin
      for (int w = 0; w <= cnt[l]; w++) begin
        logic [LINE_W-1:0] word;
        word = LINE_W'($urandom);
        if (w == 0) word[IDX_W-1:0] = IDX_W'(l);
        if (l < m) exp_r.push_back(word);
        else       exp_c.push_back(word);
        send(word);
        if (w == cnt[l]) done++;
        check("finished_rows", 32'(finished_rows), 32'(done >= m));
        check("load_done", 32'(load_done), 32'(done == m + n));
        if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
    end
    tick();
    check("words_r", got_r.size(), exp_r.size());
    check("words_c", got_c.size(), exp_c.size());
    for (int i = 0; i < exp_r.size(); i++)
      check("word_r", (i < got_r.size()) ? 32'(got_r[i]) : 32'hDEAD_BEEF, 32'(exp_r[i]));
    for (int i = 0; i < exp_c.size(); i++)
      check("word_c", (i < got_c.size()) ? 32'(got_c[i]) : 32'hDEAD_BEEF, 32'(exp_c[i]));
    check("occ_r", 32'(occ_r), exp_r.size());
    check("occ_c", 32'(occ_c), exp_c.size());
  endtask

  task automatic scenario1();
    foreach (cnt[i]) cnt[i] = 0;
    cnt[0] = 2; cnt[1] = 1; cnt[2] = 0; cnt[3] = 3;
    run_board(2, 2, 1'b0);
    check("s1_occ_r", 32'(occ_r), 5);
    check("s1_occ_c", 32'(occ_c), 5);
  endtask

  initial begin
    logic [LINE_W-1:0] v;
    #25;
    check("rst_wr_r", 32'(fifo_write_r), 0);
    check("rst_occ_r", 32'(occ_r), 0);
    rst_n = 1'b1;
    tick();
    check("rst_wr_c", 32'(fifo_write_c), 0);
    check("rst_in_r", 32'(fifo_in_r), 0);
    check("rst_in_c", 32'(fifo_in_c), 0);
    check("rst_finished", 32'(finished_rows), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_occ_c", 32'(occ_c), 0);
    check("rst_err_ovf", 32'(err_overflow), 0);
    check("rst_err_seq", 32'(err_sequence), 0);

    scenario1();
    board_parsed = 1'b1;
    tick();
    board_parsed = 1'b0;
    check("s1_err_seq", 32'(err_sequence), 0);

    // SOLVE: write and pop together hold occupancy
    mode = MODE_SOLVE;
    for (int k = 0; k < 4; k++) begin
      v = LINE_W'($urandom);
      solve_write_r = 1'b1; solve_next_r = 1'b1; solve_line_r = v;
      tick();
      check("solve_wr_r", 32'(fifo_write_r), 1);
      check("solve_in_r", 32'(fifo_in_r), 32'(v));
      check("solve_occ_r", 32'(occ_r), 5);
    end
    solve_write_r = 1'b0; solve_next_r = 1'b0;
    tick();
    check("solve_idle_wr_r", 32'(fifo_write_r), 0);
    solve_write_r = 1'b1;
    repeat (2) tick();
    solve_write_r = 1'b0;
    solve_next_c = 1'b1;
    repeat (2) tick();
    solve_next_c = 1'b0;
    check("solve_occ_r7", 32'(occ_r), 7);
    check("solve_occ_c3", 32'(occ_c), 3);
    mode = MODE_TRANSMIT;
    solve_write_c = 1'b1;
    tick();
    solve_write_c = 1'b0;
    check("tx_no_write", 32'(fifo_write_c), 0);
    check("tx_occ_c", 32'(occ_c), 3);
    do_clear();
    mode = MODE_RECEIVE;

    // Zero-option last row: H1 to rows, H2 to columns
    foreach (cnt[i]) cnt[i] = 0;
    cnt[0] = 1; cnt[1] = 0; cnt[2] = 2;
    run_board(2, 1, 1'b1);
    check("zero_err_seq", 32'(err_sequence), 0);
    do_clear();

    for (int b = 0; b < 6; b++) begin
      int m, n;
      m = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      foreach (cnt[i]) cnt[i] = 0;
      for (int l = 0; l < m + n; l++) cnt[l] = $urandom_range(0, 4);
      run_board(m, n, 1'b1);
      board_parsed = 1'b1;
      tick();
      board_parsed = 1'b0;
      check("rand_err_seq", 32'(err_sequence), 0);
      check("rand_err_ovf", 32'(err_overflow), 0);
      do_clear();
    end

    // Column FIFO full during an option word
    foreach (cnt[i]) cnt[i] = 0;
    cnt[1] = 2;
    set_counts(1, 1);
    send(16'h1200);
    send(16'h3401);
    fifo_full_c = 1'b1;
    send(16'hAAAA);
    fifo_full_c = 1'b0;
    check("full_no_write", 32'(fifo_write_c), 0);
    check("full_err_ovf", 32'(err_overflow), 1);
    check("full_occ_c", 32'(occ_c), 1);
    send(16'h5555);
    check("full_after_wr", 32'(fifo_write_c), 1);
    check("full_after_in", 32'(fifo_in_c), 32'h5555);
    check("full_occ_c2", 32'(occ_c), 2);
    check("full_load_done", 32'(load_done), 1);
    do_clear();

    // Out-of-order header, then a word after LOADED
    foreach (cnt[i]) cnt[i] = 0;
    set_counts(3, 1);
    send(16'h0000);
    send(16'h0001);
    check("seq_clean", 32'(err_sequence), 0);
    send(16'h0003);
    check("seq_err", 32'(err_sequence), 1);
    check("seq_hdr_to_r", 32'(fifo_write_r), 1);
    send(16'h0003);
    check("seq_load_done", 32'(load_done), 1);
    check("seq_hdr_to_c", 32'(fifo_write_c), 1);
    send(16'hBEEF);
    check("seq_drop_r", 32'(fifo_write_r), 0);
    check("seq_drop_c", 32'(fifo_write_c), 0);
    do_clear();

    // Asynchronous reset in the middle of an option run
    foreach (cnt[i]) cnt[i] = 0;
    cnt[0] = 2; cnt[1] = 1; cnt[2] = 0; cnt[3] = 3;
    set_counts(2, 2);
    send(16'h0000);
    send(16'h1111);
    #5 rst_n = 1'b0;
    #1;
    check("arst_wr_r", 32'(fifo_write_r), 0);
    check("arst_in_r", 32'(fifo_in_r), 0);
    check("arst_occ_r", 32'(occ_r), 0);
    check("arst_err_seq", 32'(err_sequence), 0);
    check("arst_err_ovf", 32'(err_overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    scenario1();
    check("replay_err_seq", 32'(err_sequence), 0);
    check("replay_err_ovf", 32'(err_overflow), 0);
    do_clear();

    // Solver writes outside SOLVE are ignored; pop on empty is an error
    solve_write_r = 1'b1;
    tick();
    solve_write_r = 1'b0;
    check("rx_solver_ignored", 32'(fifo_write_r), 0);
    check("rx_solver_no_err", 32'(err_sequence), 0);
    solve_next_c = 1'b1;
    tick();
    solve_next_c = 1'b0;
    check("empty_pop_err", 32'(err_sequence), 1);
    check("empty_pop_occ", 32'(occ_c), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
